// File: rtl/uart_pkg.sv
// Shared UART-manager definitions: dumper FSM states, byte width, word packing helper.
// Optional UART_DUMP_CHECKSUM_EN adds the CSUM state used by the RAM dumper.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_SEND,
        S_GUARD,
        S_WAITTX,
`ifdef UART_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } dump_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned xlen);
        return xlen / UART_BYTE_W;
    endfunction

endpackage

// File: rtl/uart_ram_dumper.sv
// Streams a contiguous RAM word range out over the UART transmitter, little-endian bytes.
// Define UART_DUMP_CHECKSUM_EN to append a two's-complement checksum byte after the data.
module uart_ram_dumper
    import uart_pkg::*;
#(
    parameter int ADDR_LEN = 14,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                dump_start,
    input  logic [ADDR_LEN-1:0] dump_addr,
    input  logic [ADDR_LEN:0]   dump_len,
    output logic                during_dump,
    output logic                dump_done,
    output logic                ram_rd_en,
    output logic [ADDR_LEN-1:0] ram_addr,
    input  logic [XLEN-1:0]     ram_rd_data,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_busy
);

    localparam int unsigned BPW   = bytes_per_word(XLEN);
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    dump_state_t         state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [ADDR_LEN:0]   rem_q, rem_d;
    logic [XLEN-1:0]     word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          txd_q, txd_d;
    logic [7:0]          lane_byte;
    logic [7:0]          tx_byte;
    logic                start_ok;
    logic                last_byte;
    logic                last_word;
`ifdef UART_DUMP_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
    logic                csum_sent_q, csum_sent_d;
`endif

    assign start_ok  = (state_q == S_IDLE) && dump_start;
    assign last_byte = (idx_q == IDX_W'(BPW - 1));
    assign last_word = (rem_q == (ADDR_LEN+1)'(1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            txd_q       <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
            sum_q       <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            txd_q       <= txd_d;
`ifdef UART_DUMP_CHECKSUM_EN
            sum_q       <= sum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (dump_start) state_d = (dump_len == '0) ? S_DONE : S_RD;
            S_RD:     state_d = S_LATCH;
            S_LATCH:  state_d = S_SEND;
            S_SEND:   if (!tx_busy) state_d = S_GUARD;
            S_GUARD:  state_d = S_WAITTX;
            S_WAITTX: begin
                if (!tx_busy) begin
`ifdef UART_DUMP_CHECKSUM_EN
                    // The checksum byte reuses GUARD/WAITTX; its completion ends the dump.
                    if (csum_sent_q)    state_d = S_DONE;
                    else if (!last_byte) state_d = S_SEND;
                    else if (!last_word) state_d = S_RD;
                    else                 state_d = S_CSUM;
`else
                    if (!last_byte)      state_d = S_SEND;
                    else if (!last_word) state_d = S_RD;
                    else                 state_d = S_DONE;
`endif
                end
            end
`ifdef UART_DUMP_CHECKSUM_EN
            S_CSUM:   if (!tx_busy) state_d = S_GUARD;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        word_d = word_q;
        idx_d  = idx_q;
        txd_d  = tx_valid ? tx_byte : txd_q;
`ifdef UART_DUMP_CHECKSUM_EN
        sum_d       = sum_q;
        csum_sent_d = csum_sent_q;
        if (tx_valid && state_q == S_SEND) sum_d = sum_q + tx_byte;
        if (tx_valid && state_q == S_CSUM) csum_sent_d = 1'b1;
        if (start_ok) begin
            sum_d       = '0;
            csum_sent_d = 1'b0;
        end
`endif
        if (start_ok) begin
            addr_d = dump_addr;
            rem_d  = dump_len;
        end
        if (state_q == S_LATCH) begin
            word_d = ram_rd_data;
            idx_d  = '0;
        end
        if (state_q == S_WAITTX && !tx_busy && last_byte
`ifdef UART_DUMP_CHECKSUM_EN
            && !csum_sent_q
`endif
            ) begin
            rem_d = rem_q - (ADDR_LEN+1)'(1);
            if (!last_word) addr_d = addr_q + ADDR_LEN'(1);
        end else if (state_q == S_WAITTX && !tx_busy && !last_byte) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        lane_byte = '0;
        for (int unsigned i = 0; i < BPW; i++) begin
            if (idx_q == IDX_W'(i)) lane_byte = word_q[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    always_comb begin
        tx_byte     = lane_byte;
        tx_valid    = (state_q == S_SEND) && !tx_busy;
`ifdef UART_DUMP_CHECKSUM_EN
        if (state_q == S_CSUM) begin
            tx_byte  = ~sum_q + 8'd1;
            tx_valid = !tx_busy;
        end
`endif
        tx_data     = tx_valid ? tx_byte : txd_q;
        ram_rd_en   = (state_q == S_RD);
        ram_addr    = addr_q;
        dump_done   = (state_q == S_DONE);
        during_dump = (state_q != S_IDLE) && (state_q != S_DONE);
    end

endmodule

// File: tb/tb_uart_ram_dumper.sv
// Directed self-checking bench for uart_ram_dumper with a RAM model and a busy-counting UART model.
// Builds with or without UART_DUMP_CHECKSUM_EN; expected byte counts follow the macro.
module tb_uart_ram_dumper;

`ifdef UART_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        dump_start = 1'b0;
    logic [13:0] dump_addr = '0;
    logic [14:0] dump_len = '0;
    logic        during_dump, dump_done, ram_rd_en, tx_valid;
    logic [13:0] ram_addr;
    logic [31:0] ram_rd_data = '0;
    logic [7:0]  tx_data;
    logic        tx_busy;

    logic [31:0] ram [0:16383];
    int          busy_cnt = 0;
    logic        stuck = 1'b0;
    int          cyc = 0;

    logic [7:0]  bytes_q[$];
    int          byte_cyc_q[$];
    logic [13:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          done_dd_bad = 0;
    int          viol = 0;
    int          tests = 0;
    int          fails = 0;
    int          s = 0;

    uart_ram_dumper #(.ADDR_LEN(14), .XLEN(32)) dut (
        .clk(clk), .rstb(rstb), .dump_start(dump_start), .dump_addr(dump_addr),
        .dump_len(dump_len), .during_dump(during_dump), .dump_done(dump_done),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = stuck | (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_rd_en) ram_rd_data <= ram[ram_addr];
        if (tx_valid) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (tx_valid) begin
            bytes_q.push_back(tx_data);
            byte_cyc_q.push_back(cyc);
            if (tx_busy) viol++;
        end
        if (ram_rd_en) begin
            rd_addr_q.push_back(ram_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (during_dump) done_dd_bad++;
        end
    end

    task automatic clear_logs();
        bytes_q.delete();
        byte_cyc_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        done_cnt = 0;
        done_dd_bad = 0;
        viol = 0;
    endtask

    task automatic start(input logic [13:0] a, input logic [14:0] l);
        clear_logs();
        @(negedge clk);
        s = cyc;
        dump_addr = a;
        dump_len = l;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0) break;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s_timeout: no dump_done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({during_dump, dump_done, ram_rd_en, ram_addr, tx_valid, tx_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {during_dump, dump_done, ram_rd_en, ram_addr, tx_valid, tx_data});
        end
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({during_dump, dump_done, ram_rd_en, tx_valid} !== 4'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got %b required 0000",
                     {during_dump, dump_done, ram_rd_en, tx_valid});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        ram[14'h10] = 32'h4433_2211;
        start(14'h10, 15'd1);
        tests++;
        if (during_dump !== 1'b1 || ram_rd_en !== 1'b1 || ram_addr !== 14'h10) begin
            fails++;
            $display("FAIL single_n1: during=%b rd_en=%b addr=%h required 1 1 0010",
                     during_dump, ram_rd_en, ram_addr);
        end
        wait_done("single", 400);
        tests++;
        if (bytes_q.size() != 4 + CS) begin
            fails++;
            $display("FAIL single_count: got %0d bytes required %0d", bytes_q.size(), 4 + CS);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bytes_q[i] !== exp[i]) begin
                fails++;
                $display("FAIL single_byte%0d: got %h required %h", i, bytes_q[i], exp[i]);
            end
        end
`ifdef UART_DUMP_CHECKSUM_EN
        tests++;
        if (bytes_q[4] !== 8'h56) begin
            fails++;
            $display("FAIL single_csum: got %h required 56", bytes_q[4]);
        end
`endif
        tests++;
        if (rd_cyc_q.size() != 1 || rd_cyc_q[0] != s + 1 || rd_addr_q[0] !== 14'h10) begin
            fails++;
            $display("FAIL single_rd: reads=%0d cyc=%0d required 1 read at %0d", rd_cyc_q.size(),
                     rd_cyc_q[0], s + 1);
        end
        tests++;
        if (byte_cyc_q[0] != s + 3) begin
            fails++;
            $display("FAIL single_first_tx: got cycle %0d required %0d", byte_cyc_q[0], s + 3);
        end
        @(negedge clk);
        tests++;
        if (done_cnt != 1 || done_dd_bad != 0 || during_dump !== 1'b0 || viol != 0) begin
            fails++;
            $display("FAIL single_done: done=%0d dd_at_done=%0d during=%b viol=%0d required 1 0 0 0",
                     done_cnt, done_dd_bad, during_dump, viol);
        end
    endtask

    task automatic test_zero_len();
        start(14'h55, 15'd0);
        repeat (4) @(negedge clk);
        tests++;
        if (done_cnt != 1 || done_cyc != s + 1 || rd_cyc_q.size() != 0 || bytes_q.size() != 0) begin
            fails++;
            $display("FAIL zero_len: done=%0d at %0d reads=%0d bytes=%0d required 1 at %0d 0 0",
                     done_cnt, done_cyc, rd_cyc_q.size(), bytes_q.size(), s + 1);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [8];
        logic [7:0] sum;
        exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        ram[14'h3FFF] = 32'hDDCC_BBAA;
        ram[14'h0000] = 32'h0403_0201;
        start(14'h3FFF, 15'd2);
        wait_done("wrap", 800);
        tests++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 14'h3FFF || rd_addr_q[1] !== 14'h0000) begin
            fails++;
            $display("FAIL wrap_addr: reads=%0d first=%h second=%h required 3fff 0000",
                     rd_addr_q.size(), rd_addr_q[0], rd_addr_q[1]);
        end
        tests++;
        if (bytes_q.size() != 8 + CS) begin
            fails++;
            $display("FAIL wrap_count: got %0d required %0d", bytes_q.size(), 8 + CS);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (bytes_q[i] !== exp[i]) begin
                fails++;
                $display("FAIL wrap_byte%0d: got %h required %h", i, bytes_q[i], exp[i]);
            end
        end
        sum = '0;
        foreach (bytes_q[i]) sum += bytes_q[i];
`ifdef UART_DUMP_CHECKSUM_EN
        tests++;
        if (sum !== 8'h00) begin
            fails++;
            $display("FAIL wrap_sum: got %h required 00", sum);
        end
`endif
    endtask

    task automatic test_ignored_start();
        int i;
        ram[14'h20] = 32'hA3A2_A1A0;
        ram[14'h21] = 32'hB3B2_B1B0;
        ram[14'h30] = 32'hDEAD_BEEF;
        start(14'h20, 15'd2);
        for (i = 0; i < 100 && bytes_q.size() == 0; i++) @(negedge clk);
        dump_addr = 14'h30;
        dump_len = 15'd5;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        wait_done("ignored", 800);
        tests++;
        if (bytes_q.size() != 8 + CS || rd_addr_q.size() != 2) begin
            fails++;
            $display("FAIL ignored_count: bytes=%0d reads=%0d required %0d 2", bytes_q.size(),
                     rd_addr_q.size(), 8 + CS);
        end
        tests++;
        if (rd_addr_q[1] !== 14'h21 || bytes_q[4] !== 8'hB0 || bytes_q[7] !== 8'hB3) begin
            fails++;
            $display("FAIL ignored_data: addr1=%h b4=%h b7=%h required 0021 b0 b3",
                     rd_addr_q[1], bytes_q[4], bytes_q[7]);
        end
    endtask

    task automatic test_stall();
        int i;
        ram[14'h10] = 32'h4433_2211;
        start(14'h10, 15'd1);
        for (i = 0; i < 100 && bytes_q.size() == 0; i++) @(negedge clk);
        stuck = 1'b1;
        repeat (1000) @(negedge clk);
        tests++;
        if (bytes_q.size() != 1 || during_dump !== 1'b1 || done_cnt != 0) begin
            fails++;
            $display("FAIL stall_hold: bytes=%0d during=%b done=%0d required 1 1 0",
                     bytes_q.size(), during_dump, done_cnt);
        end
        tests++;
        if (tx_data !== 8'h11) begin
            fails++;
            $display("FAIL stall_txdata_hold: got %h required 11", tx_data);
        end
        stuck = 1'b0;
        wait_done("stall", 400);
        tests++;
        if (bytes_q.size() != 4 + CS || bytes_q[3] !== 8'h44 || viol != 0) begin
            fails++;
            $display("FAIL stall_resume: bytes=%0d b3=%h viol=%0d required %0d 44 0",
                     bytes_q.size(), bytes_q[3], viol, 4 + CS);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        ram[14'h10] = 32'h4433_2211;
        ram[14'h40] = 32'h8765_4321;
        start(14'h10, 15'd1);
        for (i = 0; i < 200 && bytes_q.size() < 2; i++) @(negedge clk);
        #2;
        rstb = 1'b0;
        #1;
        tests++;
        if ({during_dump, dump_done, ram_rd_en, ram_addr, tx_valid, tx_data} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h required 0",
                     {during_dump, dump_done, ram_rd_en, ram_addr, tx_valid, tx_data});
        end
        @(negedge clk);
        rstb = 1'b1;
        repeat (12) @(negedge clk);
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL reset_mid_nodone: got %0d dump_done required 0", done_cnt);
        end
        start(14'h40, 15'd1);
        wait_done("reset_mid", 400);
        tests++;
        if (bytes_q.size() != 4 + CS || bytes_q[0] !== 8'h21 || bytes_q[1] !== 8'h43 ||
            bytes_q[2] !== 8'h65 || bytes_q[3] !== 8'h87 || rd_addr_q[0] !== 14'h40) begin
            fails++;
            $display("FAIL reset_mid_redump: n=%0d bytes=%h %h %h %h addr=%h required 21 43 65 87 0040",
                     bytes_q.size(), bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3], rd_addr_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_zero_len();
        test_wrap();
        test_ignored_start();
        test_stall();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
